// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: modes, FSM states, shift
// direction and control-register bit positions.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Configuration strobe/registers from the S00_AXI slave and the LED-side
// outputs of the sequencer.
interface led_pattern_sequencer_if #(
    parameter int NUM_LEDS           = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic                          cfg_update;
    logic [C_S_AXI_DATA_WIDTH-1:0] cfg_ctrl;
    logic [C_S_AXI_DATA_WIDTH-1:0] cfg_pattern;
    logic [C_S_AXI_DATA_WIDTH-1:0] cfg_period;
    logic [C_S_AXI_DATA_WIDTH-1:0] cfg_duty;
    logic [NUM_LEDS-1:0]           led;
    logic                          step_tick;
    logic                          running;

    modport master (
        output cfg_update, cfg_ctrl, cfg_pattern, cfg_period, cfg_duty,
        input  led, step_tick, running
    );

    modport slave (
        input  cfg_update, cfg_ctrl, cfg_pattern, cfg_period, cfg_duty,
        output led, step_tick, running
    );
endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter with a brightness compare; all-ones duty means
// fully on.
module led_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);
    logic [PWM_BITS-1:0] pwm_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    assign pwm_on = (pwm_cnt < duty) || (&duty);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives board LEDs from the myLed slave registers: IDLE/RUN FSM, step
// counter, pattern shifter (static/blink/rotate/bounce) and PWM dimming.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS           = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int PWM_BITS           = 8
) (
    input logic                    s00_axi_aclk,
    input logic                    s00_axi_aresetn,
    led_pattern_sequencer_if.slave bus
);
    localparam int W = C_S_AXI_DATA_WIDTH;

    state_e              state_q, state_d;
    logic                en_q;
    mode_e               mode_q;
    logic [W-1:0]        period_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [NUM_LEDS-1:0] pat_q;
    logic                phase_q;
    dir_e                dir_q;
    logic [W-1:0]        step_cnt_q;
    logic [NUM_LEDS-1:0] led_q;

    logic                run_active;
    logic [W-1:0]        term;
    logic                tick;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] disp;
    logic                unused_cfg_bits;

    assign unused_cfg_bits = ^{bus.cfg_ctrl[W-1:CTRL_MODE_MSB+1],
                               bus.cfg_pattern[W-1:NUM_LEDS],
                               bus.cfg_duty[W-1:PWM_BITS]};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Period 0 is treated as 1 so the block ticks every cycle.
    assign term       = (period_q == '0) ? '0 : period_q - W'(1);
    assign run_active = (state_q == ST_RUN) && en_q;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        tick    = 1'b0;
        if (bus.cfg_update) begin
            state_d = bus.cfg_ctrl[CTRL_EN] ? ST_RUN : ST_IDLE;
        end else if (run_active && (step_cnt_q == term)) begin
            tick = 1'b1;
        end
    end

    // A cfg_update always wins over a coincident terminal count.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            en_q       <= 1'b0;
            mode_q     <= MODE_STATIC;
            period_q   <= '0;
            duty_q     <= '0;
            pat_q      <= '0;
            phase_q    <= 1'b0;
            dir_q      <= DIR_LEFT;
            step_cnt_q <= '0;
        end else if (bus.cfg_update) begin
            en_q       <= bus.cfg_ctrl[CTRL_EN];
            mode_q     <= mode_e'(bus.cfg_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB]);
            period_q   <= bus.cfg_period;
            duty_q     <= bus.cfg_duty[PWM_BITS-1:0];
            pat_q      <= bus.cfg_pattern[NUM_LEDS-1:0];
            phase_q    <= 1'b1;
            dir_q      <= DIR_LEFT;
            step_cnt_q <= '0;
        end else if (tick) begin
            step_cnt_q <= '0;
            case (mode_q)
                MODE_BLINK:  phase_q <= ~phase_q;
                MODE_ROTATE: pat_q   <= {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    // Hitting an edge spends one tick turning around.
                    if (dir_q == DIR_LEFT) begin
                        if (!pat_q[NUM_LEDS-1]) pat_q <= pat_q << 1;
                        else                    dir_q <= DIR_RIGHT;
                    end else begin
                        if (!pat_q[0]) pat_q <= pat_q >> 1;
                        else           dir_q <= DIR_LEFT;
                    end
                end
                default: ;
            endcase
        end else if (run_active) begin
            step_cnt_q <= step_cnt_q + W'(1);
        end
    end

    led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk    (s00_axi_aclk),
        .rst_n  (s00_axi_aresetn),
        .duty   (duty_q),
        .pwm_on (pwm_on)
    );

    assign disp = ((mode_q == MODE_BLINK) && !phase_q) ? '0 : pat_q;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            led_q <= '0;
        end else begin
            led_q <= run_active ? (disp & {NUM_LEDS{pwm_on}}) : '0;
        end
    end

    assign bus.led       = led_q;
    assign bus.step_tick = tick;
    assign bus.running   = (state_q == ST_RUN);

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Downstream consumer of the S00_AXI register bank inside the myLed IP: takes the four 32-bit slave registers (control, pattern, step period, brightness) and drives the board LEDs. It produces timed patterns (static, blink, rotate, bounce) at a programmable step rate, dimmed by a free-running PWM. All timing is derived from the AXI clock. Register values are captured only on a one-cycle update strobe raised by the slave on any completed AXI write.

## Interface
Parameters:
- NUM_LEDS, 4, LED count (≥2)
- C_S_AXI_DATA_WIDTH, 32, register width
- PWM_BITS, 8, PWM counter/duty width

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; asynchronous, active-low
- cfg_update  in  1  one-cycle pulse: capture all cfg_* inputs
- cfg_ctrl  in  C_S_AXI_DATA_WIDTH  slv_reg0: [0] enable, [2:1] mode
- cfg_pattern  in  C_S_AXI_DATA_WIDTH  slv_reg1: [NUM_LEDS-1:0] pattern seed
- cfg_period  in  C_S_AXI_DATA_WIDTH  slv_reg2: clocks per step
- cfg_duty  in  C_S_AXI_DATA_WIDTH  slv_reg3: [PWM_BITS-1:0] brightness
- led  out  NUM_LEDS  LED drive, registered
- step_tick  out  1  one-cycle pulse on each pattern step
- running  out  1  high in RUN state

## Operation
- Shadow registers en_q, mode_q, period_q, duty_q load on cfg_update; reset to 0.
- Modes: 00 STATIC, 01 BLINK, 10 ROTATE, 11 BOUNCE.
- States: IDLE, RUN. IDLE→RUN on cfg_update with cfg_ctrl[0]=1. RUN→IDLE on cfg_update with cfg_ctrl[0]=0. cfg_update in RUN with enable=1 restarts.
- Restart/entry: step counter cleared, pat_q ← cfg_pattern[NUM_LEDS-1:0], blink phase ← 1, direction ← left.
- Step counter: counts 0..max(period_q,1)-1. step_tick asserts in the cycle the count equals the terminal value; period_q=0 behaves as 1 (tick every cycle).
- On step_tick:
  - STATIC: no change.
  - BLINK: phase toggles; displayed pattern = phase ? pat_q : 0.
  - ROTATE: pat_q rotates left by 1, MSB→LSB.
  - BOUNCE: left shift while pat_q[NUM_LEDS-1]=0, else direction flips right. Right shift while pat_q[0]=0, else flips left. A flip cycle only changes direction; the shift happens on the next tick. Pattern 0 or all-ones stays constant.
- PWM: pwm_cnt free-runs 0..2^PWM_BITS-1 in all states. pwm_on = (pwm_cnt < duty_q) or duty_q = all-ones.
- led = displayed pattern & {NUM_LEDS{pwm_on}} in RUN; 0 in IDLE.

## Timing
- Reset values: led=0, step_tick=0, running=0, all counters and shadows 0, state IDLE.
- cfg_update at edge N → shadows/state valid after N. led reflects the new pattern at edge N+1 (one output register).
- First step_tick after restart occurs max(period_q,1) cycles after the restart edge.
- cfg_update coincident with a terminal count: cfg_update wins, no step applied, step_tick suppressed.
- cfg_update with an unchanged register value still restarts the sequence.
- Reset asserted mid-run: all outputs clear immediately (asynchronously). After release the block stays IDLE until the next cfg_update.
- Period is a full 32-bit unsigned compare; no wrap below terminal value.

## Structure
- Shared package/header led_seq_pkg: mode encodings, ctrl bit positions (CTRL_EN=0, CTRL_MODE=2:1), state encoding.
- Sub-module led_pwm_gen (PWM_BITS): pwm_cnt plus compare → pwm_on.
- Top holds the FSM, step counter, pattern shifter and output register. Instantiated beside the S00_AXI slave in myLed_v1_0.

## Test plan
- Reset, no cfg_update for 100 cycles → led=0, running=0, step_tick never asserts.
- ctrl=0x1 (STATIC), pattern=0x5, duty=0xFF, period=10 → led=0x5 constant from N+1; step_tick every 10 cycles.
- ctrl=0x5 (ROTATE), pattern=0x1, period=4, duty=0xFF → led 0x1,0x2,0x4,0x8,0x1, changing every 4 cycles.
- ctrl=0x7 (BOUNCE), pattern=0x1, period=1 → pat_q sequence 1,2,4,8,8,4,2,1,1,2 (one flip tick at each end).
- ctrl=0x3 (BLINK), pattern=0xF, duty=0x40, period=2 → led alternates 0xF/0 per step. While "on", led is high 64 of every 256 cycles.
- ROTATE running, assert s00_axi_aresetn low mid-step → led=0 immediately. Release, then cfg_update ctrl=0x0 → IDLE, led stays 0. period=0 with ctrl=0x5 → led rotates every cycle.
